bus_mux_pipe: RTL

Parametrised, registered datapath bus multiplexer. It is the successor of the fixed 24-source, 5-bit-select CPU bus mux.
- Sources are selected by one-hot drive enables (the Rout/PCout/MDRout/… control lines), not an encoded select.
- Adds configurable pipeline latency, hold-or-zero idle policy, multi-driver detection and a transfer counter.
- Sits between the register file, special registers and the single internal CPU bus.

---
 rtl/bus_mux_pipe_pkg.sv | 19 +
 rtl/bus_mux_pipe_if.sv | 41 ++++
 rtl/bus_mux_pipe_prio_enc.sv | 23 ++
 rtl/bus_mux_pipe.sv | 106 ++++++++++
 4 files changed

// File: rtl/bus_mux_pipe_pkg.sv
// Shared definitions for the CPU internal bus multiplexer: default sizes,
// CPU bus source indices and an index-width helper.
package bus_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NSRC  = 24;

  typedef enum logic [4:0] {
    R0, R1, R2, R3, R4, R5, R6, R7,
    R8, R9, R10, R11, R12, R13, R14, R15,
    HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN
  } cpu_src_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_mux_pipe_if.sv
// Bus-side signal bundle of bus_mux_pipe. Optional bus_par exists only when
// BUS_MUX_PARITY_EN is defined.
interface bus_mux_pipe_if #(
  parameter int WIDTH = bus_pkg::DEF_WIDTH,
  parameter int NSRC  = bus_pkg::DEF_NSRC,
  parameter int CNT_W = 16,
  parameter int SRC_W = bus_pkg::clog2_min1(NSRC)
);

  // Contract: no valid/ready backpressure. Inputs are sampled on every rising
  // edge; bus_valid qualifies bus_out and the pipeline never stalls.
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       drive_en;
  logic                  err_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SRC_W-1:0]      bus_src;
  logic                  multi_drive;
  logic                  multi_drive_sticky;
  logic [CNT_W-1:0]      xfer_cnt;
`ifdef BUS_MUX_PARITY_EN
  logic                  bus_par;
`endif

  modport master (
    output src_data, drive_en, err_clr,
    input  bus_out, bus_valid, bus_src, multi_drive, multi_drive_sticky, xfer_cnt
`ifdef BUS_MUX_PARITY_EN
    , bus_par
`endif
  );

  modport slave (
    input  src_data, drive_en, err_clr,
    output bus_out, bus_valid, bus_src, multi_drive, multi_drive_sticky, xfer_cnt
`ifdef BUS_MUX_PARITY_EN
    , bus_par
`endif
  );

endinterface

// File: rtl/bus_mux_pipe_prio_enc.sv
// One-hot request priority encoder: lowest set index wins, plus any/multi flags.
// Purely combinational; also used by the register-file write decoder.
module prio_enc_onehot #(
  parameter int N  = 24,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic          multi
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    valid = |req;
    multi = (req & (req - {{(N-1){1'b0}}, 1'b1})) != '0;
  end

endmodule

// File: rtl/bus_mux_pipe.sv
// Registered CPU bus multiplexer with one-hot drive enables, 1- or 2-cycle latency,
// hold/zero idle policy, multi-driver detection and a saturating transfer counter.
// Define BUS_MUX_PARITY_EN to add the pipelined bus_par output.
module bus_mux_pipe
  import bus_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NSRC      = DEF_NSRC,
  parameter int LAT       = 1,
  parameter int HOLD_IDLE = 1,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           reset,
  bus_mux_pipe_if.slave bus
);

  localparam int SRC_W = clog2_min1(NSRC);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SRC_W-1:0] src;
    logic             valid;
    logic             multi;
`ifdef BUS_MUX_PARITY_EN
    logic             par;
`endif
  } stage_t;

  logic [SRC_W-1:0] enc_idx;
  logic             enc_valid;
  logic             enc_multi;

  stage_t s1_d, s1_q;
  stage_t out_d, out_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  prio_enc_onehot #(.N(NSRC), .IW(SRC_W)) u_enc (
    .req   (bus.drive_en),
    .idx   (enc_idx),
    .valid (enc_valid),
    .multi (enc_multi)
  );

  // Select stage: idle cycles either keep the previous word or load zero.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = enc_valid;
    s1_d.multi = enc_multi;
    if (enc_valid) begin
      s1_d.data = bus.src_data[int'(enc_idx) * WIDTH +: WIDTH];
      s1_d.src  = enc_idx;
    end else if (HOLD_IDLE == 0) begin
      s1_d.data = '0;
      s1_d.src  = '0;
    end
`ifdef BUS_MUX_PARITY_EN
    s1_d.par = ^s1_d.data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  // out_d is whatever lands on the outputs at the next edge.
  generate
    if (LAT == 2) begin : g_lat2
      stage_t s2_q;
      always_ff @(posedge clk) begin
        if (reset) s2_q <= '0;
        else       s2_q <= s1_q;
      end
      assign out_d = s1_q;
      assign out_q = s2_q;
    end else begin : g_lat1
      assign out_d = s1_d;
      assign out_q = s1_q;
    end
  endgenerate

  // Sticky and counter track out_d so they stay aligned with bus_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (out_d.multi)      sticky_q <= 1'b1;
      else if (bus.err_clr) sticky_q <= 1'b0;
      if (out_d.valid && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.bus_out            = out_q.data;
  assign bus.bus_valid          = out_q.valid;
  assign bus.bus_src            = out_q.src;
  assign bus.multi_drive        = out_q.multi;
  assign bus.multi_drive_sticky = sticky_q;
  assign bus.xfer_cnt           = cnt_q;
`ifdef BUS_MUX_PARITY_EN
  assign bus.bus_par            = out_q.par;
`endif

endmodule
